// File: rtl/line_tracker_bands.sv
// line_tracker_bands: pclk-domain multi-band line tracker.
//   Classifies captured pixels against runtime RGB444 thresholds and keeps a
//   matched count and x-sum for NUM_BANDS horizontal bands. The bands are
//   stacked upward from the bottom of the previous frame's height. On each
//   vsync rise the sums are snapshotted. One shared restoring divider then
//   computes each band's centroid, and the records stream out in band order.
// Ports:
//   pclk, reset_n          clock, async active-low reset
//   vsync, href, we, pix   camera sync, line valid, write strobe, pixel
//   thr_*, min_px          colour thresholds, detection count threshold
//   frame_pulse            one-cycle pulse per frame boundary
//   width_px, height_ln    geometry measured over the last frame
//   res_*                  valid/ready result stream, one record per band
//   busy, overrun_cnt      sequence in progress, frames dropped while busy

// Per-band accumulator: band-window test and the count/x-sum registers.
module line_tracker_band_acc #(
  parameter int K          = 0,
  parameter int BAND_LINES = 16,
  parameter int CNT_W      = 16,
  parameter int ACC_W      = 32
) (
  input  logic             pclk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             hit,
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  logic [CNT_W-1:0] h_prev,
  output logic [ACC_W-1:0] sum_n,
  output logic [ACC_W-1:0] sum_x
);
  int   hi, lo;
  logic in_band;

  // Band K spans [h_prev-(K+1)*BL, h_prev-K*BL). The lower bound is clamped
  // at 0. An upper bound <= 0, which includes h_prev == 0, matches nothing.
  always_comb begin
    hi = int'(h_prev) - K * BAND_LINES;
    lo = hi - BAND_LINES;
    if (lo < 0) lo = 0;
    in_band = (hi > 0) && (int'(y) >= lo) && (int'(y) < hi);
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      sum_n <= '0;
      sum_x <= '0;
    end else if (clr) begin
      sum_n <= '0;
      sum_x <= '0;
    end else if (hit && in_band) begin
      sum_n <= sum_n + ACC_W'(1);
      sum_x <= sum_x + ACC_W'(x);
    end
  end
endmodule

module line_tracker_bands #(
  parameter int NUM_BANDS  = 4,
  parameter int BAND_LINES = 16,
  parameter int PIX_W      = 12,
  parameter int CNT_W      = 16,
  parameter int ACC_W      = 32,
  localparam int BAND_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              vsync,
  input  logic              href,
  input  logic              we,
  input  logic [PIX_W-1:0]  pix,
  input  logic [3:0]        thr_r_min,
  input  logic [3:0]        thr_g_min,
  input  logic [3:0]        thr_b_max,
  input  logic [ACC_W-1:0]  min_px,
  output logic              frame_pulse,
  output logic [CNT_W-1:0]  width_px,
  output logic [CNT_W-1:0]  height_ln,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [BAND_W-1:0] res_band,
  output logic [CNT_W-1:0]  res_cx,
  output logic [ACC_W-1:0]  res_count,
  output logic              res_detected,
  output logic              busy,
  output logic [7:0]        overrun_cnt
);
  localparam int DCW = $clog2(ACC_W) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DIV, PRESENT} state_t;
  state_t state, state_nx;

  logic href_d, vsync_d, href_rise, vsync_rise;
  logic [CNT_W-1:0] x, y, width_latch, height_latch, h_prev;
  logic line_wr, width_set, colour_ok, hit;

  logic [NUM_BANDS-1:0][ACC_W-1:0] acc_n, acc_x, sh_n, sh_x;
  logic [BAND_W-1:0] band;
  logic [ACC_W-1:0]  rem, dvd, dsr;
  logic [ACC_W:0]    trial;
  logic [DCW-1:0]    div_cnt;

  assign href_rise  = ~href_d & href;
  assign vsync_rise = ~vsync_d & vsync;
  assign busy       = (state != IDLE);

  assign colour_ok = (pix[11:8] >= thr_r_min) && (pix[7:4] >= thr_g_min) &&
                     (pix[3:0] <= thr_b_max);
  // A write that coincides with the frame boundary is discarded.
  assign hit = we && colour_ok && !vsync_rise;

  // Line/geometry tracking. A line counts only once the next href rise shows
  // that it received at least one write.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      href_d <= 1'b0; vsync_d <= 1'b0; frame_pulse <= 1'b0;
      x <= '0; y <= '0; line_wr <= 1'b0; width_set <= 1'b0;
      width_latch <= '0; height_latch <= '0; h_prev <= '0;
      width_px <= '0; height_ln <= '0; overrun_cnt <= '0;
    end else begin
      href_d      <= href;
      vsync_d     <= vsync;
      frame_pulse <= vsync_rise;
      if (vsync_rise) begin
        width_px     <= width_latch;
        height_ln    <= height_latch;
        h_prev       <= height_latch;
        x            <= '0;
        y            <= '0;
        line_wr      <= 1'b0;
        width_set    <= 1'b0;
        width_latch  <= '0;
        height_latch <= '0;
        if (state != IDLE && overrun_cnt != 8'hFF)
          overrun_cnt <= overrun_cnt + 8'd1;
      end else if (href_rise) begin
        x       <= '0;
        line_wr <= 1'b0;
        if (line_wr) begin
          y            <= y + CNT_W'(1);
          height_latch <= y + CNT_W'(1);
          if (!width_set) begin
            width_latch <= x;
            width_set   <= 1'b1;
          end
        end
      end else if (we) begin
        x       <= x + CNT_W'(1);
        line_wr <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_band
    line_tracker_band_acc #(
      .K(k), .BAND_LINES(BAND_LINES), .CNT_W(CNT_W), .ACC_W(ACC_W)
    ) u_acc (
      .pclk(pclk), .reset_n(reset_n), .clr(vsync_rise), .hit(hit),
      .x(x), .y(y), .h_prev(h_prev), .sum_n(acc_n[k]), .sum_x(acc_x[k])
    );
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (vsync_rise) state_nx = LOAD;
      LOAD:    state_nx = (sh_n[band] == '0) ? PRESENT : DIV;
      DIV:     if (div_cnt == DCW'(ACC_W - 1)) state_nx = PRESENT;
      PRESENT: if (res_valid && res_ready)
                 state_nx = (band == BAND_W'(NUM_BANDS - 1)) ? IDLE : LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // Restoring step: shift the next dividend bit into the remainder and keep
  // the subtraction when it does not borrow.
  assign trial = {rem, dvd[ACC_W-1]} - {1'b0, dsr};

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      sh_n <= '0; sh_x <= '0; band <= '0;
      rem <= '0; dvd <= '0; dsr <= '0; div_cnt <= '0;
      res_valid <= 1'b0; res_band <= '0; res_cx <= '0;
      res_count <= '0; res_detected <= 1'b0;
    end else begin
      if (vsync_rise && state == IDLE) begin
        sh_n <= acc_n;
        sh_x <= acc_x;
        band <= '0;
      end
      case (state)
        LOAD: begin
          rem     <= '0;
          dsr     <= sh_n[band];
          dvd     <= (sh_n[band] == '0) ? '0 : sh_x[band];
          div_cnt <= '0;
        end
        DIV: begin
          rem     <= trial[ACC_W] ? {rem[ACC_W-2:0], dvd[ACC_W-1]} : trial[ACC_W-1:0];
          dvd     <= {dvd[ACC_W-2:0], ~trial[ACC_W]};
          div_cnt <= div_cnt + DCW'(1);
        end
        PRESENT: begin
          // Fields load once on entry and hold until the handshake.
          if (!res_valid) begin
            res_valid    <= 1'b1;
            res_band     <= band;
            res_cx       <= dvd[CNT_W-1:0];
            res_count    <= sh_n[band];
            res_detected <= (sh_n[band] != '0) && (sh_n[band] >= min_px);
          end else if (res_ready) begin
            res_valid <= 1'b0;
            band      <= (band == BAND_W'(NUM_BANDS - 1)) ? '0 : band + BAND_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_line_tracker_bands.sv
// Testbench for line_tracker_bands. It drives 64x80 frames and pushes the
// hand-computed band records into a queue. A negedge monitor pops and
// compares each accepted record and checks that fields hold under stall.
module tb_line_tracker_bands;
  localparam int NB = 4, BL = 16, PIX_W = 12, CNT_W = 16, ACC_W = 32, BW = 2;

  logic pclk, reset_n, vsync, href, we, res_ready, frame_pulse, res_valid;
  logic res_detected, busy;
  logic [PIX_W-1:0] pix;
  logic [3:0] thr_r_min, thr_g_min, thr_b_max;
  logic [ACC_W-1:0] min_px, res_count;
  logic [CNT_W-1:0] width_px, height_ln, res_cx;
  logic [BW-1:0] res_band;
  logic [7:0] overrun_cnt;

  line_tracker_bands #(
    .NUM_BANDS(NB), .BAND_LINES(BL), .PIX_W(PIX_W), .CNT_W(CNT_W), .ACC_W(ACC_W)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .vsync(vsync), .href(href), .we(we),
    .pix(pix), .thr_r_min(thr_r_min), .thr_g_min(thr_g_min),
    .thr_b_max(thr_b_max), .min_px(min_px), .frame_pulse(frame_pulse),
    .width_px(width_px), .height_ln(height_ln), .res_valid(res_valid),
    .res_ready(res_ready), .res_band(res_band), .res_cx(res_cx),
    .res_count(res_count), .res_detected(res_detected), .busy(busy),
    .overrun_cnt(overrun_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {int band; int cx; longint cnt; bit det;} rec_t;
  rec_t exp_q[$];
  rec_t mon_e;
  int errors = 0, checks = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge pclk); #1;
  endtask

  task automatic push(input int b, input int cx, input longint cnt, input bit det);
    rec_t r;
    r.band = b; r.cx = cx; r.cnt = cnt; r.det = det;
    exp_q.push_back(r);
  endtask

  task automatic push_zero4();
    for (int b = 0; b < NB; b++) push(b, 0, 0, 1'b0);
  endtask

  // mode 1: line 79, x 10..19 ; mode 2: x 40 on lines 47, 48, 63
  function automatic bit is_hit(input int m, input int y, input int x);
    if (m == 1) return (y == 79) && (x >= 10) && (x <= 19);
    if (m == 2) return (x == 40) && (y == 47 || y == 48 || y == 63);
    return 1'b0;
  endfunction

  // 80 lines of 64 writes, then a trailing href so the last line is counted.
  task automatic run_frame(input int m);
    for (int y = 0; y < 80; y++) begin
      href = 1'b1; tick();
      for (int x = 0; x < 64; x++) begin
        we = 1'b1;
        pix = is_hit(m, y, x) ? 12'hFF0 : 12'h00F;
        tick();
      end
      we = 1'b0; pix = '0; href = 1'b0; tick();
    end
    href = 1'b1; tick();
    href = 1'b0; tick();
  endtask

  // Returns right after the edge that sees the rise; vsync is already low again.
  task automatic vs_pulse();
    vsync = 1'b1; tick();
    vsync = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!res_valid && n < 200) begin tick(); n++; end
    chk("wait_valid_timeout", res_valid, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin tick(); n++; end
    chk("wait_idle_timeout", busy, 0);
  endtask

  // Scoreboard monitor and stall-stability check.
  logic stall_d = 1'b0;
  logic [BW-1:0] s_band;
  logic [CNT_W-1:0] s_cx;
  logic [ACC_W-1:0] s_cnt;
  logic s_det;

  always @(negedge pclk) begin
    if (reset_n && res_valid && res_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: band=%0d cx=%0d count=%0d", res_band, res_cx, res_count);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(res_band) != mon_e.band || int'(res_cx) != mon_e.cx ||
            longint'(res_count) != mon_e.cnt || res_detected != mon_e.det) begin
          errors++;
          $display("FAIL record: got band=%0d cx=%0d count=%0d det=%0d, expected band=%0d cx=%0d count=%0d det=%0d",
                   res_band, res_cx, res_count, res_detected,
                   mon_e.band, mon_e.cx, mon_e.cnt, mon_e.det);
        end
      end
    end
    if (reset_n && stall_d) begin
      checks++;
      if (!res_valid || res_band != s_band || res_cx != s_cx ||
          res_count != s_cnt || res_detected != s_det) begin
        errors++;
        $display("FAIL stall_stable: got valid=%0d band=%0d cx=%0d count=%0d, expected valid=1 band=%0d cx=%0d count=%0d",
                 res_valid, res_band, res_cx, res_count, s_band, s_cx, s_cnt);
      end
    end
    stall_d <= reset_n && res_valid && !res_ready;
    s_band  <= res_band;
    s_cx    <= res_cx;
    s_cnt   <= res_count;
    s_det   <= res_detected;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; vsync = 1'b0; href = 1'b0; we = 1'b0; pix = '0;
    thr_r_min = 4'd8; thr_g_min = 4'd8; thr_b_max = 4'd3;
    min_px = 32'd1; res_ready = 1'b1;
    repeat (3) tick();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_pulse", frame_pulse, 0);
    chk("rst_width", width_px, 0);
    chk("rst_height", height_ln, 0);
    chk("rst_overrun", overrun_cnt, 0);
    reset_n = 1'b1; tick();

    // Frame 1: no previous height, so all bands are empty.
    push_zero4();
    run_frame(0);
    vs_pulse();
    chk("f1_frame_pulse", frame_pulse, 1);
    chk("f1_width", width_px, 64);
    chk("f1_height", height_ln, 80);
    tick();
    chk("f1_pulse_clear", frame_pulse, 0);
    wait_idle();

    // Frame 2: 10 matches on line 79 -> band0 count 10, cx (10+..+19)/10 = 14.
    push(0, 14, 10, 1'b1); push(1, 0, 0, 1'b0); push(2, 0, 0, 1'b0); push(3, 0, 0, 1'b0);
    run_frame(1);
    vs_pulse();
    chk("f2_height", height_ln, 80);
    tick();
    wait_idle();

    // Frame 3: lines 48 and 63 fall in band1 and line 47 falls in band2.
    push(0, 0, 0, 1'b0); push(1, 40, 2, 1'b1); push(2, 40, 1, 1'b1); push(3, 0, 0, 1'b0);
    run_frame(2);
    vs_pulse(); tick();
    wait_idle();

    // Frame 4: min_px above the count clears detected.
    min_px = 32'd11;
    push(0, 14, 10, 1'b0); push(1, 0, 0, 1'b0); push(2, 0, 0, 1'b0); push(3, 0, 0, 1'b0);
    run_frame(1);
    vs_pulse(); tick();
    wait_idle();
    min_px = 32'd1;

    // Frame 5: stall band0 for 50 cycles.
    push(0, 14, 10, 1'b1); push(1, 0, 0, 1'b0); push(2, 0, 0, 1'b0); push(3, 0, 0, 1'b0);
    run_frame(1);
    res_ready = 1'b0;
    vs_pulse(); tick();
    wait_valid();
    chk("bp_first_band", res_band, 0);
    repeat (50) tick();
    chk("bp_busy", busy, 1);
    res_ready = 1'b1;
    wait_idle();

    // Frame 6: vsync while busy is dropped and counted.
    push(0, 14, 10, 1'b1); push(1, 0, 0, 1'b0); push(2, 0, 0, 1'b0); push(3, 0, 0, 1'b0);
    run_frame(1);
    res_ready = 1'b0;
    vs_pulse();
    chk("f6_height", height_ln, 80);
    tick();
    wait_valid();
    vs_pulse();
    chk("ovr_frame_pulse", frame_pulse, 1);
    chk("ovr_count1", overrun_cnt, 1);
    tick();
    res_ready = 1'b1;
    wait_idle();

    // Saturation: start an empty sequence and stall it through 300 frames.
    res_ready = 1'b0;
    push_zero4();
    vs_pulse(); tick();
    for (int i = 1; i <= 300; i++) begin
      vs_pulse(); tick();
      if (i == 253) chk("ovr_count254", overrun_cnt, 254);
    end
    chk("ovr_saturated", overrun_cnt, 255);
    res_ready = 1'b1;
    wait_idle();

    // Frame 7: re-establish a height of 80 (previous height was 0).
    push_zero4();
    run_frame(1);
    vs_pulse(); tick();
    wait_idle();

    // Frame 8: reset while band0 is dividing; its records are dropped.
    run_frame(1);
    vs_pulse();
    repeat (5) tick();
    chk("mid_div_busy", busy, 1);
    reset_n = 1'b0; tick();
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_width", width_px, 0);
    chk("mid_rst_height", height_ln, 0);
    chk("mid_rst_overrun", overrun_cnt, 0);
    chk("mid_rst_count", res_count, 0);
    chk("mid_rst_cx", res_cx, 0);
    repeat (2) tick();
    reset_n = 1'b1; tick();

    // Frame 9: normal after reset (no previous height -> empty bands).
    push_zero4();
    run_frame(0);
    vs_pulse();
    chk("f9_width", width_px, 64);
    chk("f9_height", height_ln, 80);
    tick();
    wait_idle();
    repeat (5) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
